// File: rtl/coeff_bank_dbuf_if.sv
// coeff_bank_dbuf_if: load stream, swap, read selects and coefficient outputs of the coefficient bank
interface coeff_bank_dbuf_if #(
  parameter int Width = 4,
  parameter int SelW  = 4
);
  logic                    load_start_i;
  logic                    wr_valid_i;
  logic signed [Width-1:0] wr_data_i;
  logic                    wr_ready_o;
  logic                    load_done_o;
  logic                    shadow_full_o;
  logic                    swap_i;
  logic [SelW-1:0]         sel_x_i;
  logic [SelW-1:0]         sel_y_i;
  logic signed [Width-1:0] coeff_x_o;
  logic signed [Width-1:0] coeff_y_o;
  logic signed [Width-1:0] offset_o;
  modport master (
    output load_start_i, wr_valid_i, wr_data_i, swap_i, sel_x_i, sel_y_i,
    input  wr_ready_o, load_done_o, shadow_full_o, coeff_x_o, coeff_y_o, offset_o
  );
  modport slave (
    input  load_start_i, wr_valid_i, wr_data_i, swap_i, sel_x_i, sel_y_i,
    output wr_ready_o, load_done_o, shadow_full_o, coeff_x_o, coeff_y_o, offset_o
  );
endinterface

// File: rtl/coeff_bank_dbuf.sv
// coeff_bank_dbuf: double-buffered coefficient bank (clk, async rst, bus: serial shadow load, swap, registered X/Y reads, offset)
module coeff_bank_dbuf #(
  parameter int Width  = 4,
  parameter int NCoeff = 10,
  parameter int SelW   = 4,
  parameter int PtrW   = 5
) (
  input logic             clk,
  input logic             rst,
  coeff_bank_dbuf_if.slave bus
);
  localparam int Last = 2 * NCoeff;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2;
  logic [1:0]              state_q, state_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic                    done_q, wr_en, at_last, commit;
  logic signed [Width-1:0] shd_q [Last+1];
  logic signed [Width-1:0] ax_q [NCoeff];
  logic signed [Width-1:0] ay_q [NCoeff];
  logic signed [Width-1:0] off_q, cx_q, cy_q, rd_x, rd_y;
  // a restart in LOAD drops any write offered in the same cycle
  assign wr_en   = state_q == LOAD && bus.wr_valid_i && !bus.load_start_i;
  assign at_last = ptr_q == PtrW'(Last);
  assign commit  = state_q == FULL && bus.swap_i;
  // LoadStart wins in every state; in FULL the commit still happens on the same edge
  assign state_d = bus.load_start_i ? LOAD : (wr_en && at_last) ? FULL : commit ? IDLE : state_q;
  assign ptr_d   = bus.load_start_i ? '0 : wr_en ? ptr_q + 1'b1 : ptr_q;
  assign rd_x    = 32'(bus.sel_x_i) < NCoeff ? ax_q[bus.sel_x_i] : '0;
  assign rd_y    = 32'(bus.sel_y_i) < NCoeff ? ay_q[bus.sel_y_i] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      off_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      for (int i = 0; i <= Last; i++) shd_q[i] <= '0;
      for (int i = 0; i < NCoeff; i++) begin
        ax_q[i] <= '0;
        ay_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= wr_en && at_last;
      cx_q    <= rd_x;
      cy_q    <= rd_y;
      if (wr_en) shd_q[ptr_q] <= bus.wr_data_i;
      if (commit) begin
        for (int i = 0; i < NCoeff; i++) begin
          ax_q[i] <= shd_q[i];
          ay_q[i] <= shd_q[NCoeff+i];
        end
        off_q <= shd_q[Last];
      end
    end
  assign bus.wr_ready_o    = state_q == LOAD;
  assign bus.load_done_o   = done_q;
  assign bus.shadow_full_o = state_q == FULL;
  assign bus.coeff_x_o     = cx_q;
  assign bus.coeff_y_o     = cy_q;
  assign bus.offset_o      = off_q;
endmodule

// File: tb/tb_coeff_bank_dbuf.sv
// tb_coeff_bank_dbuf: scoreboard bench for coeff_bank_dbuf with directed load/swap/read vectors
module tb_coeff_bank_dbuf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  coeff_bank_dbuf_if #(.Width(8), .SelW(4)) bus();
  coeff_bank_dbuf #(.Width(8), .NCoeff(10), .SelW(4), .PtrW(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  typedef struct {int x; int y; int o; int r; int f; int d;} exp_t;
  exp_t  exp_q[$];
  string nm_q[$];
  int    acc_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  e;
  string n;
  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.wr_valid_i && bus.wr_ready_o && !bus.load_start_i) begin
      if (acc_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept: got word %0d, required no accept", int'(bus.wr_data_i));
      end else chk("accept", int'(bus.wr_data_i), acc_q.pop_front());
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      chk({n, ".x"}, int'(bus.coeff_x_o), e.x);
      chk({n, ".y"}, int'(bus.coeff_y_o), e.y);
      chk({n, ".off"}, int'(bus.offset_o), e.o);
      chk({n, ".ready"}, int'(bus.wr_ready_o), e.r);
      chk({n, ".full"}, int'(bus.shadow_full_o), e.f);
      chk({n, ".done"}, int'(bus.load_done_o), e.d);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_st(string name, int x, int y, int o, int r, int f, int d);
    exp_q.push_back('{x, y, o, r, f, d});
    nm_q.push_back(name);
  endtask
  task automatic stream(int base, int step, int cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 8'(base + step * i);
      acc_q.push_back(base + step * i);
      tick();
    end
    bus.wr_valid_i = 1'b0;
  endtask
  task automatic start();
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
  endtask
  initial begin
    bus.load_start_i = 1'b0;
    bus.wr_valid_i   = 1'b0;
    bus.wr_data_i    = '0;
    bus.swap_i       = 1'b0;
    bus.sel_x_i      = '0;
    bus.sel_y_i      = '0;
    repeat (2) tick();
    rst = 1'b0;
    bus.sel_x_i = 4'd3;
    bus.sel_y_i = 4'd9;
    tick();
    expect_st("reset", 0, 0, 0, 0, 0, 0);
    start();
    expect_st("start1", 0, 0, 0, 1, 0, 0);
    stream(1, 1, 21);
    expect_st("done1", 0, 0, 0, 0, 1, 1);
    tick();
    expect_st("pulse_end1", 0, 0, 0, 0, 1, 0);
    bus.swap_i = 1'b1; bus.sel_x_i = 4'd0; bus.sel_y_i = 4'd9;
    tick();
    bus.swap_i = 1'b0;
    expect_st("swap1", 0, 0, 21, 0, 0, 0);
    tick();
    expect_st("read1", 1, 20, 21, 0, 0, 0);
    start();
    for (int c = 0; c <= 40; c++) begin
      bus.wr_valid_i = (c % 2) == 0;
      bus.wr_data_i  = bus.wr_valid_i ? 8'(101 + c / 2) : 8'd85;
      if (bus.wr_valid_i) acc_q.push_back(101 + c / 2);
      tick();
      if (c == 10) expect_st("hold2", 1, 20, 21, 1, 0, 0);
    end
    bus.wr_valid_i = 1'b0;
    expect_st("done2", 1, 20, 21, 0, 1, 1);
    bus.swap_i = 1'b1; bus.sel_x_i = 4'd4; bus.sel_y_i = 4'd0;
    tick();
    bus.swap_i = 1'b0;
    expect_st("swap2", 5, 11, 121, 0, 0, 0);
    tick();
    expect_st("read2", 105, 111, 121, 0, 0, 0);
    bus.sel_x_i = 4'd2; bus.sel_y_i = 4'd5;
    start();
    stream(-1, -1, 10);
    bus.swap_i = 1'b1;
    tick();
    bus.swap_i = 1'b0;
    expect_st("swap_in_load", 103, 116, 121, 1, 0, 0);
    stream(-11, -1, 11);
    expect_st("done3", 103, 116, 121, 0, 1, 1);
    bus.swap_i = 1'b1;
    tick();
    bus.swap_i = 1'b0;
    expect_st("swap3", 103, 116, -21, 0, 0, 0);
    tick();
    expect_st("read3", -3, -16, -21, 0, 0, 0);
    start();
    stream(50, 1, 7);
    bus.load_start_i = 1'b1; bus.wr_valid_i = 1'b1; bus.wr_data_i = 8'd99;
    tick();
    bus.load_start_i = 1'b0; bus.wr_valid_i = 1'b0;
    expect_st("restart", -3, -16, -21, 1, 0, 0);
    stream(30, 1, 21);
    expect_st("done4", -3, -16, -21, 0, 1, 1);
    bus.wr_valid_i = 1'b1; bus.wr_data_i = 8'd7;
    tick();
    bus.wr_valid_i = 1'b0;
    expect_st("full_hold", -3, -16, -21, 0, 1, 0);
    bus.swap_i = 1'b1; bus.sel_x_i = 4'd7; bus.sel_y_i = 4'd0;
    tick();
    bus.swap_i = 1'b0;
    expect_st("swap4", -8, -11, 50, 0, 0, 0);
    tick();
    expect_st("read4", 37, 40, 50, 0, 0, 0);
    start();
    stream(1, 1, 5);
    #2;
    rst = 1'b1;
    expect_st("async_rst", 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    bus.swap_i = 1'b1;
    tick();
    bus.swap_i = 1'b0;
    tick();
    expect_st("swap_idle", 0, 0, 0, 0, 0, 0);
    bus.sel_x_i = 4'd12; bus.sel_y_i = 4'd1;
    start();
    stream(60, 1, 21);
    expect_st("done6", 0, 0, 0, 0, 1, 1);
    bus.swap_i = 1'b1; bus.load_start_i = 1'b1;
    tick();
    bus.swap_i = 1'b0; bus.load_start_i = 1'b0;
    expect_st("swap_ls", 0, 0, 80, 1, 0, 0);
    tick();
    expect_st("sel12", 0, 71, 80, 1, 0, 0);
    bus.sel_x_i = 4'd9;
    tick();
    expect_st("x9", 69, 71, 80, 1, 0, 0);
    repeat (2) tick();
    chk("accepts_left", acc_q.size(), 0);
    chk("checks_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coeff_bank_dbuf.md
Name: coeff_bank_dbuf

Overview:
Double-buffered, parametrised coefficient bank for the neural-network datapath. It holds NCoeff X-weights, NCoeff Y-weights and one offset per neuron. A new coefficient set is loaded serially into a shadow bank through a valid/ready stream while the neuron keeps reading the active bank. An explicit Swap commits the shadow set atomically. Two independent registered read ports (X, Y) feed the MAC stage.

Parameters:
Width, 4, signed coefficient/offset width in bits
NCoeff, 10, coefficients per read channel (X and Y each), >=2
SelW, 4, select/pointer width; must satisfy 2**SelW >= NCoeff
PtrW, 5, load pointer width; must satisfy 2**PtrW >= 2*NCoeff+1

Ports:
CLK  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
LoadStart  input  1  begin/restart a serial load of the shadow bank
WrValid  input  1  WrData valid
WrData  input  Width  signed coefficient word, order X0..X(N-1), Y0..Y(N-1), Offset
WrReady  output  1  bank accepts WrData this cycle
LoadDone  output  1  one-cycle pulse: shadow bank complete
ShadowFull  output  1  complete shadow set waiting for Swap
Swap  input  1  commit shadow bank to active bank
SELCoeffX  input  SelW  X read select
SELCoeffY  input  SelW  Y read select
OutCoeffX  output  Width  signed, registered X coefficient
OutCoeffY  output  Width  signed, registered Y coefficient
OffsetOut  output  Width  signed active offset

Behaviour:
- Reset (async, active-high): shadow and active banks = 0; OutCoeffX/OutCoeffY = 0; OffsetOut = 0; state IDLE; ptr = 0; WrReady = 0; LoadDone = 0; ShadowFull = 0. A reset during LOAD discards the partial load.
- FSM states: IDLE, LOAD, FULL.
- IDLE: WrReady = 0. LoadStart -> LOAD, ptr <= 0. Swap is ignored and the active bank is unchanged.
- LOAD: WrReady = 1. On WrValid & WrReady, shadow[ptr] <= WrData and ptr <= ptr+1. WrValid=0 stalls with no change.
  - The write at ptr = 2*NCoeff (the offset) moves the FSM to FULL, and LoadDone = 1 for exactly the next cycle.
  - LoadStart in LOAD restarts the load: ptr <= 0. Any write in that same cycle is dropped. Previously written shadow words stay until overwritten.
  - Swap in LOAD is ignored.
- FULL: WrReady = 0, ShadowFull = 1. WrValid is ignored.
  - Swap: active bank <= shadow bank, all 2*NCoeff+1 words in one edge; -> IDLE.
  - LoadStart without Swap discards the pending set: -> LOAD, ptr <= 0.
  - Swap and LoadStart together: commit first, then -> LOAD, ptr <= 0.
- Shadow bank contents are not cleared by Swap.
- Read ports: 1-cycle latency.
  - At each edge, OutCoeffX <= activeX[SELCoeffX] and OutCoeffY <= activeY[SELCoeffY], using active contents before that edge.
  - Select >= NCoeff gives 0.
  - Swap at edge t: outputs from edge t still show the old set; edge t+1 shows the new set.
- OffsetOut is driven directly from the active offset register and changes at the Swap edge.
- No arithmetic is performed. Values are stored and passed bit-exact, with sign preserved.

Test Plan:
- Reset, then select X=3, Y=9 -> OutCoeffX=0, OutCoeffY=0, OffsetOut=0, WrReady=0, ShadowFull=0.
- LoadStart, then stream 21 words 1..21 (Width=8) with WrValid high -> LoadDone pulse 1 cycle after the last accept; ShadowFull=1; active outputs still 0. Swap -> OffsetOut=21 at the swap edge; SELX=0 gives OutCoeffX=1 and SELY=9 gives OutCoeffY=20, one edge later.
- Stream with WrValid toggled every other cycle -> exactly 21 accepts; data in order; no accept while WrValid=0.
- Reads while loading a new set (values -1..-21) -> outputs keep the old set until Swap. After Swap, SELX=2 -> OutCoeffX=-3 (sign intact).
- LoadStart asserted mid-load at ptr=7 -> pointer restarts; the following 21 words define the set. Async reset mid-load -> all outputs 0 immediately with no clock edge; a later Swap is ignored in IDLE.
- Swap and LoadStart together in FULL -> new set active; WrReady=1 next cycle. Select 12 (>=NCoeff) -> output 0.
